// File: rtl/truth_table_bist.sv
// On-chip truth-table checker: walks every input pattern into a combinational
// block, samples its 1-bit response after a settle delay, and tallies mismatches.
module truth_table_bist #(
    parameter int                   N_IN   = 3,
    parameter logic [2**N_IN-1:0]   EXPECT = 8'b0011_1100,
    parameter int                   SETTLE = 2
) (
    input  logic            clk,
    input  logic            n_reset,
    input  logic            start,
    input  logic            resp,
    output logic [N_IN-1:0] stim,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   fail_count,
    output logic [N_IN-1:0] first_fail,
    output logic            first_fail_valid
);

    localparam logic [N_IN-1:0] LAST_VEC    = N_IN'(2**N_IN - 1);
    localparam logic [3:0]      SETTLE_LAST = 4'(SETTLE - 1);

    typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

    state_t          state_q, state_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [N_IN:0]   fail_count_q, fail_count_d;
    logic [N_IN-1:0] first_fail_q, first_fail_d;
    logic            ffv_q, ffv_d;
    logic            pass_q, pass_d;
    logic            done_q, done_d;
    logic            mismatch;

    assign mismatch = (resp != EXPECT[stim_q]);

    always_comb begin
        state_d      = state_q;
        stim_d       = stim_q;
        cnt_d        = cnt_q;
        fail_count_d = fail_count_q;
        first_fail_d = first_fail_q;
        ffv_d        = ffv_q;
        pass_d       = pass_q;
        done_d       = done_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = DRIVE;
                    stim_d       = '0;
                    cnt_d        = '0;
                    fail_count_d = '0;
                    first_fail_d = '0;
                    ffv_d        = 1'b0;
                    pass_d       = 1'b0;
                    done_d       = 1'b0;
                end
            end
            DRIVE: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == SETTLE_LAST) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                if (mismatch) begin
                    fail_count_d = fail_count_q + 1'b1;
                    if (!ffv_q) begin
                        first_fail_d = stim_q;
                        ffv_d        = 1'b1;
                    end
                end
                if (stim_q == LAST_VEC) begin
                    // pass must reflect the tally including the final vector
                    state_d = DONE;
                    done_d  = 1'b1;
                    pass_d  = (fail_count_d == '0);
                end else begin
                    stim_d  = stim_q + 1'b1;
                    cnt_d   = '0;
                    state_d = DRIVE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q      <= IDLE;
            stim_q       <= '0;
            cnt_q        <= '0;
            fail_count_q <= '0;
            first_fail_q <= '0;
            ffv_q        <= 1'b0;
            pass_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            stim_q       <= stim_d;
            cnt_q        <= cnt_d;
            fail_count_q <= fail_count_d;
            first_fail_q <= first_fail_d;
            ffv_q        <= ffv_d;
            pass_q       <= pass_d;
            done_q       <= done_d;
        end
    end

    assign stim             = stim_q;
    assign busy             = (state_q == DRIVE) || (state_q == CHECK);
    assign done             = done_q;
    assign pass             = pass_q;
    assign fail_count       = fail_count_q;
    assign first_fail       = first_fail_q;
    assign first_fail_valid = ffv_q;

endmodule
